// File: rtl/monster_spawn_scheduler_if.sv
// Signal bundle between the score/state logic, the slot controllers and monster_spawn_scheduler.
interface monster_spawn_scheduler_if #(
  parameter int unsigned N_SLOTS = 4
) ();
  logic [1:0]         game_state;
  logic               tick;
  logic [13:0]        score;
  logic [N_SLOTS-1:0] slot_alive;
  logic [N_SLOTS-1:0] slot_hit;
  logic [N_SLOTS-1:0] spawn_pulse;
  logic [9:0]         spawn_x;
  logic [3:0]         active_cnt;
  logic [7:0]         kill_count;
  logic [1:0]         sched_state;

  modport master (
    output game_state, tick, score, slot_alive, slot_hit,
    input  spawn_pulse, spawn_x, active_cnt, kill_count, sched_state
  );

  modport slave (
    input  game_state, tick, score, slot_alive, slot_hit,
    output spawn_pulse, spawn_x, active_cnt, kill_count, sched_state
  );
endinterface

// File: rtl/monster_spawn_scheduler.sv
// Monster spawn scheduler: score-threshold / cooldown / cap gated, round-robin slots, LFSR x position.
// Optional MON_SCHED_DIFFICULTY_EN shrinks the score gap as kills accumulate.
module monster_spawn_scheduler #(
  parameter int unsigned N_SLOTS        = 4,
  parameter int unsigned MAX_ACTIVE     = 3,
  parameter int unsigned SPAWN_GAP      = 500,
  parameter int unsigned COOLDOWN_TICKS = 30,
  parameter int unsigned MAP_W          = 640,
  parameter int unsigned MON_W          = 120,
  parameter logic [9:0]  LFSR_SEED      = 10'h1A5
) (
  input  logic                    clk,
  input  logic                    rst,
  monster_spawn_scheduler_if.slave bus
);

  localparam int unsigned SW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [9:0]  X_RANGE = 10'(MAP_W - MON_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SPAWN    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [9:0]         lfsr;
  logic [14:0]        score_ref;
  logic [15:0]        cd_cnt;
  logic [SW-1:0]      last_slot;
  logic [N_SLOTS-1:0] spawn_pulse;
  logic [9:0]         spawn_x;
  logic [3:0]         active_cnt;
  logic [7:0]         kill_count;

  logic               playing;
  logic [14:0]        gap;
  logic               spawn_ok;
  logic [SW-1:0]      sel;
  logic [8:0]         kill_sum;

  function automatic logic [3:0] popcnt(input logic [N_SLOTS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  assign playing = (bus.game_state == 2'd2);

`ifdef MON_SCHED_DIFFICULTY_EN
  logic [1:0] gap_shift;
  always_comb begin
    gap_shift = (kill_count[7:3] > 5'd3) ? 2'd3 : kill_count[4:3];
    gap       = 15'(SPAWN_GAP) >> gap_shift;
  end
`else
  assign gap = 15'(SPAWN_GAP);
`endif

  assign spawn_ok = ({1'b0, bus.score} >= (score_ref + gap))
                 && (active_cnt < 4'(MAX_ACTIVE))
                 && (|(~bus.slot_alive));

  // Round-robin search starting just after the last slot used, wrapping at N_SLOTS.
  always_comb begin
    logic       found;
    logic [SW-1:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_SLOTS; k++) begin
      idx = SW'((32'(last_slot) + k) % N_SLOTS);
      if (!found && !bus.slot_alive[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign kill_sum = 9'(kill_count) + 9'(popcnt(bus.slot_hit));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = ARMED;
      ARMED:    if (spawn_ok) state_nxt = SPAWN;
      SPAWN:    state_nxt = COOLDOWN;
      COOLDOWN: if (bus.tick && cd_cnt <= 16'd1) state_nxt = ARMED;
      default:  state_nxt = IDLE;
    endcase
    if (!playing) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  // Spawn outputs are registered on the ARMED->SPAWN edge so the pulse coincides with SPAWN.
  always_ff @(posedge clk) begin
    if (rst || !playing) begin
      spawn_pulse <= '0;
      spawn_x     <= '0;
      active_cnt  <= '0;
      kill_count  <= '0;
      score_ref   <= '0;
      cd_cnt      <= '0;
      last_slot   <= SW'(N_SLOTS - 1);
    end else begin
      spawn_pulse <= '0;
      active_cnt  <= popcnt(bus.slot_alive);
      kill_count  <= (kill_sum > 9'd255) ? 8'hFF : kill_sum[7:0];
      if (state == ARMED && spawn_ok) begin
        spawn_pulse <= {{(N_SLOTS-1){1'b0}}, 1'b1} << sel;
        spawn_x     <= (lfsr <= X_RANGE) ? lfsr : (lfsr - X_RANGE);
        last_slot   <= sel;
        score_ref   <= {1'b0, bus.score};
        cd_cnt      <= 16'(COOLDOWN_TICKS);
      end else if (state == COOLDOWN && bus.tick && cd_cnt != '0) begin
        cd_cnt <= cd_cnt - 16'd1;
      end
    end
  end

  assign bus.spawn_pulse = spawn_pulse;
  assign bus.spawn_x     = spawn_x;
  assign bus.active_cnt  = active_cnt;
  assign bus.kill_count  = kill_count;
  assign bus.sched_state = state;

endmodule

// File: tb/tb_monster_spawn_scheduler.sv
// Directed self-checking bench for monster_spawn_scheduler at default parameters.
module tb_monster_spawn_scheduler;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;
  logic [9:0] m_lfsr;
  logic [9:0] m_prev;

  monster_spawn_scheduler_if #(.N_SLOTS(4)) bus ();

  monster_spawn_scheduler #(
    .N_SLOTS(4), .MAX_ACTIVE(3), .SPAWN_GAP(500), .COOLDOWN_TICKS(30),
    .MAP_W(640), .MON_W(120), .LFSR_SEED(10'h1A5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^10 + x^7 + 1, m_prev is the value seen before the latest edge.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (rst) m_lfsr <= 10'h1A5;
    else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fold_x(input logic [9:0] v);
    return (v <= 10'd520) ? 32'(v) : 32'(v - 10'd520);
  endfunction

  task automatic check_spawn(input string tag, input logic [3:0] exp_pulse);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (bus.sched_state == 2'd2) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_pulse"}, 32'(bus.spawn_pulse), 32'(exp_pulse));
      check({tag, "_x"}, 32'(bus.spawn_x), fold_x(m_prev));
      check({tag, "_x_range"}, 32'(bus.spawn_x <= 10'd520), 32'd1);
    end
  endtask

  task automatic check_pulse_drops(input string tag);
    step();
    check({tag, "_cooldown"}, 32'(bus.sched_state), 32'd3);
    check({tag, "_pulse_off"}, 32'(bus.spawn_pulse), 32'd0);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
  endtask

  task automatic idle_cycles(input string tag, input int unsigned n, input logic [1:0] exp_state);
    for (int unsigned i = 0; i < n; i++) step();
    check({tag, "_state"}, 32'(bus.sched_state), 32'(exp_state));
    check({tag, "_nopulse"}, 32'(bus.spawn_pulse), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.game_state = 2'd0;
    bus.tick       = 1'b0;
    bus.score      = '0;
    bus.slot_alive = '0;
    bus.slot_hit   = '0;

    // Reset
    step();
    step();
    check("rst_state", 32'(bus.sched_state), 32'd0);
    check("rst_pulse", 32'(bus.spawn_pulse), 32'd0);
    check("rst_kills", 32'(bus.kill_count), 32'd0);
    check("rst_x", 32'(bus.spawn_x), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr), 32'h1A5);
    rst = 1'b0;
    step();
    check("notplay_state", 32'(bus.sched_state), 32'd0);

    // Threshold
    bus.game_state = 2'd2;
    step();
    check("armed", 32'(bus.sched_state), 32'd1);
    idle_cycles("score0", 3, 2'd1);
    bus.score = 14'd499;
    idle_cycles("score499", 3, 2'd1);
    bus.score = 14'd500;
    check_spawn("sp1", 4'b0001);
    check_pulse_drops("sp1");

    // Cooldown with a large score jump, then round-robin skipping alive slot 1
    bus.slot_alive = 4'b0011;
    bus.score = 14'd2500;
    ticks(29);
    check("cd29_state", 32'(bus.sched_state), 32'd3);
    check("cd29_nopulse", 32'(bus.spawn_pulse), 32'd0);
    check("active_cnt2", 32'(bus.active_cnt), 32'd2);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check("cd30_armed", 32'(bus.sched_state), 32'd1);
    check_spawn("sp2", 4'b0100);
    check_pulse_drops("sp2");

    // Active cap blocks spawning until a slot clears
    bus.slot_alive = 4'b0111;
    ticks(30);
    bus.score = 14'd3500;
    idle_cycles("cap", 5, 2'd1);
    check("active_cnt3", 32'(bus.active_cnt), 32'd3);
    bus.slot_alive = 4'b0110;
    check_spawn("sp3", 4'b1000);
    check_pulse_drops("sp3");

    // Kill counting
    bus.slot_hit = 4'b0011;
    step();
    bus.slot_hit = 4'b0000;
    check("kills2", 32'(bus.kill_count), 32'd2);
    bus.slot_hit = 4'b0001;
    for (int i = 0; i < 6; i++) step();
    bus.slot_hit = 4'b0000;
    check("kills8", 32'(bus.kill_count), 32'd8);
    ticks(30);
    bus.score = 14'd3749;
    idle_cycles("gap249", 5, 2'd1);
    bus.score = 14'd3750;
`ifdef MON_SCHED_DIFFICULTY_EN
    check_spawn("sp4", 4'b0001);
`else
    idle_cycles("gap250", 5, 2'd1);
    bus.score = 14'd4000;
    check_spawn("sp4", 4'b0001);
`endif
    check_pulse_drops("sp4");
    bus.slot_hit = 4'b0001;
    for (int i = 0; i < 300; i++) step();
    check("kills_sat", 32'(bus.kill_count), 32'd255);
    bus.slot_hit = 4'b0011;
    step();
    bus.slot_hit = 4'b0000;
    check("kills_sat2", 32'(bus.kill_count), 32'd255);
    check("still_cd", 32'(bus.sched_state), 32'd3);

    // Abort during cooldown
    bus.game_state = 2'd0;
    step();
    check("abort_state", 32'(bus.sched_state), 32'd0);
    check("abort_kills", 32'(bus.kill_count), 32'd0);
    check("abort_pulse", 32'(bus.spawn_pulse), 32'd0);
    check("abort_active", 32'(bus.active_cnt), 32'd0);
    idle_cycles("abort_hold", 3, 2'd0);

    // Re-entry restarts at slot 0 with score_ref cleared; abort mid-SPAWN
    bus.game_state = 2'd2;
    bus.score = 14'd500;
    step();
    check("reenter_armed", 32'(bus.sched_state), 32'd1);
    check_spawn("sp5", 4'b0001);
    bus.game_state = 2'd1;
    step();
    check("abort_spawn_state", 32'(bus.sched_state), 32'd0);
    check("abort_spawn_pulse", 32'(bus.spawn_pulse), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
